// File: rtl/receptor_serial_32.sv
// Serial receiver for fixed-width words: 1 start bit (0), ANCHO data bits LSB-first,
// 1 stop bit (1), line idle high. Bit timing is derived from the system clock, and
// each received word is presented with a valid/ack handshake. Framing and overrun
// errors are flagged with one-cycle pulses.
module receptor_serial_32 #(
  parameter int unsigned FRECUENCIA = 100000000,
  parameter int unsigned TASA_BITS  = 1500000,
  parameter int unsigned ANCHO      = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rx_in,
  output logic [ANCHO-1:0] dato_out,
  output logic             dato_valido,
  input  logic             dato_ack,
  output logic             error_trama,
  output logic             desborde
);

  localparam int unsigned CICLOS_BIT = FRECUENCIA / TASA_BITS;
  localparam int unsigned MEDIO_BIT  = CICLOS_BIT / 2;
  localparam int unsigned CntW       = (CICLOS_BIT > 1) ? $clog2(CICLOS_BIT) : 1;
  localparam int unsigned BitW       = (ANCHO > 1) ? $clog2(ANCHO) : 1;

  localparam logic [CntW-1:0] CntBitFin   = CntW'(CICLOS_BIT - 1);
  localparam logic [CntW-1:0] CntMedioFin = CntW'(MEDIO_BIT - 1);
  localparam logic [BitW-1:0] BitFin      = BitW'(ANCHO - 1);

  typedef enum logic [2:0] {
    StReposo,
    StInicio,
    StDatos,
    StParada,
    StEsperaAlto
  } estado_e;

  estado_e          estado_q, estado_d;
  logic             sync1_q, rx_sync_q;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [BitW-1:0]  bit_q, bit_d;
  logic [ANCHO-1:0] shift_q, shift_d;
  logic [ANCHO-1:0] dato_q, dato_d;
  logic             valido_q, valido_d;
  logic             error_q, error_d;
  logic             desborde_q, desborde_d;
  logic             entrega;

  logic fin_medio, fin_bit, ultimo_bit;
  assign fin_medio  = (cnt_q == CntMedioFin);
  assign fin_bit    = (cnt_q == CntBitFin);
  assign ultimo_bit = (bit_q == BitFin);

  // Two-flop synchronizer; resets to idle-high so the FSM only arms on a real low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      sync1_q   <= rx_in;
      rx_sync_q <= sync1_q;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q   <= StReposo;
      cnt_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      dato_q     <= '0;
      valido_q   <= 1'b0;
      error_q    <= 1'b0;
      desborde_q <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      dato_q     <= dato_d;
      valido_q   <= valido_d;
      error_q    <= error_d;
      desborde_q <= desborde_d;
    end
  end

  // Next-state logic.
  always_comb begin
    estado_d = estado_q;
    unique case (estado_q)
      StReposo: begin
        if (!rx_sync_q) estado_d = StInicio;
      end
      StInicio: begin
        // A start bit that is gone by mid-bit was a glitch.
        if (fin_medio) estado_d = rx_sync_q ? StReposo : StDatos;
      end
      StDatos: begin
        if (fin_bit && ultimo_bit) estado_d = StParada;
      end
      StParada: begin
        if (fin_bit) estado_d = rx_sync_q ? StReposo : StEsperaAlto;
      end
      StEsperaAlto: begin
        // A held-low line (break) must return high before the next frame.
        if (rx_sync_q) estado_d = StReposo;
      end
      default: estado_d = StReposo;
    endcase
  end

  // Counters, shift register and stop-bit outcome for the current state.
  always_comb begin
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    entrega = 1'b0;
    error_d = 1'b0;
    unique case (estado_q)
      StReposo: begin
        cnt_d = '0;
        bit_d = '0;
      end
      StInicio: begin
        if (fin_medio) begin
          cnt_d = '0;
          bit_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDatos: begin
        if (fin_bit) begin
          cnt_d   = '0;
          // Shift in at the MSB so the first (LSB) bit ends at bit 0.
          shift_d = {rx_sync_q, shift_q[ANCHO-1:1]};
          bit_d   = ultimo_bit ? '0 : bit_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StParada: begin
        if (fin_bit) begin
          cnt_d = '0;
          if (rx_sync_q) entrega = 1'b1;
          else           error_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StEsperaAlto: begin
        cnt_d = '0;
      end
      default: begin
        cnt_d = '0;
        bit_d = '0;
      end
    endcase
  end

  // Output handshake: load, drop-with-overrun, or consume on ack.
  always_comb begin
    dato_d     = dato_q;
    valido_d   = valido_q;
    desborde_d = 1'b0;
    if (entrega) begin
      // An ack in the delivery cycle frees the slot for the new word.
      if (!valido_q || dato_ack) begin
        dato_d   = shift_q;
        valido_d = 1'b1;
      end else begin
        desborde_d = 1'b1;
      end
    end else if (valido_q && dato_ack) begin
      valido_d = 1'b0;
    end
  end

  assign dato_out    = dato_q;
  assign dato_valido = valido_q;
  assign error_trama = error_q;
  assign desborde    = desborde_q;

endmodule

// File: tb/tb_receptor_serial_32.sv
// Bench for receptor_serial_32: a behavioural model pushes expected events (word,
// framing error, overrun) into a queue at stimulus time; a monitor pops and compares
// whenever the receiver presents something.
module tb_receptor_serial_32;

  localparam int BIT_CLKS = 100000000 / 1500000;  // 66
  localparam int LATENCIA = 2 + BIT_CLKS / 2 + 33 * BIT_CLKS + 1;  // 2214
  localparam int FRAME_CLKS = 34 * BIT_CLKS;

  localparam int K_WORD = 0;
  localparam int K_ERR  = 1;
  localparam int K_OVR  = 2;

  typedef struct {
    int          kind;
    logic [31:0] data;
  } evento_t;

  logic        clk;
  logic        clk_en;
  logic        rst_n;
  logic        rx_in;
  logic [31:0] dato_out;
  logic        dato_valido;
  logic        dato_ack;
  logic        error_trama;
  logic        desborde;

  int checks;
  int errors;
  int err_cnt;
  int ovr_cnt;
  logic pend;
  evento_t exp_q[$];

  receptor_serial_32 dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_in      (rx_in),
    .dato_out   (dato_out),
    .dato_valido(dato_valido),
    .dato_ack   (dato_ack),
    .error_trama(error_trama),
    .desborde   (desborde)
  );

  initial begin
    clk = 1'b0;
    forever begin
      #5;
      if (clk_en) clk = ~clk;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  task automatic expect_event(input int kind);
    evento_t it;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected event: got kind %0d data %h required none", kind, dato_out);
    end else begin
      it = exp_q.pop_front();
      chk("event kind", kind, it.kind);
      if (kind == K_WORD) chk("word data", dato_out, it.data);
    end
  endtask

  // Reference model: what one frame should produce, given handshake state.
  task automatic model_frame(input logic [31:0] w, input logic stop_ok, input logic ack_deliv);
    evento_t it;
    it.data = w;
    if (!stop_ok) begin
      it.kind = K_ERR;
    end else if (pend && !ack_deliv) begin
      it.kind = K_OVR;
    end else begin
      it.kind = K_WORD;
      pend = 1'b1;
    end
    exp_q.push_back(it);
  endtask

  // Called aligned #1 after a rising edge; returns aligned the same way.
  task automatic send_frame(input logic [31:0] w, input logic stop);
    rx_in = 1'b0;
    repeat (BIT_CLKS) @(posedge clk);
    #1;
    for (int i = 0; i < 32; i++) begin
      rx_in = w[i];
      repeat (BIT_CLKS) @(posedge clk);
      #1;
    end
    rx_in = stop;
    repeat (BIT_CLKS) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_ack();
    int n;
    n = 0;
    while (!dato_valido && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("valid before ack", dato_valido, 1'b1);
    dato_ack = 1'b1;
    @(posedge clk);
    #1;
    dato_ack = 1'b0;
    pend = 1'b0;
    chk("valid after ack", dato_valido, 1'b0);
  endtask

  // Monitor: sample away from the active edge and classify what the DUT presents.
  initial begin
    logic pv;
    logic pa;
    pv = 1'b0;
    pa = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pv = 1'b0;
        pa = 1'b0;
      end else begin
        if (error_trama) begin
          err_cnt++;
          expect_event(K_ERR);
        end
        if (desborde) begin
          ovr_cnt++;
          expect_event(K_OVR);
        end
        // A fresh word: valid newly raised, or still valid after the old one was taken.
        if (dato_valido && (!pv || pa)) expect_event(K_WORD);
        pv = dato_valido;
        pa = dato_ack;
      end
    end
  end

  initial begin
    int n;
    int e0;
    int o0;
    logic [31:0] w;
    logic ok;
    checks   = 0;
    errors   = 0;
    err_cnt  = 0;
    ovr_cnt  = 0;
    pend     = 1'b0;
    clk_en   = 1'b1;
    rx_in    = 1'b1;
    dato_ack = 1'b0;
    rst_n    = 1'b0;
    #2;
    chk("reset dato_out", dato_out, 32'h0);
    chk("reset dato_valido", dato_valido, 1'b0);
    chk("reset error_trama", error_trama, 1'b0);
    chk("reset desborde", desborde, 1'b0);
    idle(5);
    rst_n = 1'b1;

    // Idle line: nothing happens.
    idle(5000);
    chk("idle valid", dato_valido, 1'b0);
    chk("idle events", err_cnt + ovr_cnt, 0);

    // Single frame with latency measurement and hold/ack behaviour.
    model_frame(32'hA5A51234, 1'b1, 1'b0);
    n = 0;
    fork
      send_frame(32'hA5A51234, 1'b1);
      begin
        do begin
          @(posedge clk);
          #1;
          n++;
        end while (!dato_valido && n < 3000);
      end
    join
    checks++;
    if (n < LATENCIA - 2 || n > LATENCIA + 2) begin
      errors++;
      $display("FAIL latency: got %0d required %0d +-2", n, LATENCIA);
    end
    chk("single data", dato_out, 32'hA5A51234);
    idle(200);
    chk("hold valid", dato_valido, 1'b1);
    chk("hold data", dato_out, 32'hA5A51234);
    do_ack();

    // Glitch: short low pulse must not start a frame.
    e0 = err_cnt;
    rx_in = 1'b0;
    idle(10);
    rx_in = 1'b1;
    idle(300);
    chk("glitch valid", dato_valido, 1'b0);
    chk("glitch error", err_cnt - e0, 0);
    model_frame(32'h00000001, 1'b1, 1'b0);
    send_frame(32'h00000001, 1'b1);
    chk("post-glitch data", dato_out, 32'h00000001);
    do_ack();

    // Framing error followed by a break, then a good frame.
    e0 = err_cnt;
    model_frame(32'hFFFFFFFF, 1'b0, 1'b0);
    send_frame(32'hFFFFFFFF, 1'b0);
    rx_in = 1'b0;
    idle(500);
    rx_in = 1'b1;
    idle(20);
    chk("framing error pulses", err_cnt - e0, 1);
    chk("framing valid", dato_valido, 1'b0);
    chk("framing queue", exp_q.size(), 0);
    model_frame(32'h12345678, 1'b1, 1'b0);
    send_frame(32'h12345678, 1'b1);
    chk("post-error data", dato_out, 32'h12345678);
    do_ack();

    // Overrun: second frame dropped while the first is unacknowledged.
    o0 = ovr_cnt;
    model_frame(32'h11111111, 1'b1, 1'b0);
    send_frame(32'h11111111, 1'b1);
    model_frame(32'h22222222, 1'b1, 1'b0);
    send_frame(32'h22222222, 1'b1);
    idle(20);
    chk("overrun data", dato_out, 32'h11111111);
    chk("overrun pulses", ovr_cnt - o0, 1);
    chk("overrun valid", dato_valido, 1'b1);
    do_ack();

    // Ack in the exact delivery cycle of the second frame.
    o0 = ovr_cnt;
    fork
      begin
        model_frame(32'h11111111, 1'b1, 1'b0);
        send_frame(32'h11111111, 1'b1);
        model_frame(32'h22222222, 1'b1, 1'b1);
        send_frame(32'h22222222, 1'b1);
      end
      begin
        repeat (FRAME_CLKS + LATENCIA - 1) @(posedge clk);
        #1;
        dato_ack = 1'b1;
        @(posedge clk);
        #1;
        dato_ack = 1'b0;
      end
    join
    idle(20);
    chk("ack-deliv data", dato_out, 32'h22222222);
    chk("ack-deliv valid", dato_valido, 1'b1);
    chk("ack-deliv overrun", ovr_cnt - o0, 0);
    chk("ack-deliv queue", exp_q.size(), 0);

    // Reset with the clock stopped while a word is held.
    clk_en = 1'b0;
    #50;
    rst_n = 1'b0;
    #2;
    chk("stopped-clk reset valid", dato_valido, 1'b0);
    chk("stopped-clk reset data", dato_out, 32'h0);
    pend   = 1'b0;
    clk_en = 1'b1;
    idle(5);
    rst_n = 1'b1;
    idle(50);

    // Reset mid-frame (data bit 15) with a word pending and the clock running.
    model_frame(32'h5A5A0F0F, 1'b1, 1'b0);
    send_frame(32'h5A5A0F0F, 1'b1);
    fork
      send_frame(32'hDEADBEEF, 1'b1);
      begin
        repeat (16 * BIT_CLKS + BIT_CLKS / 2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #2;
        chk("midframe reset valid", dato_valido, 1'b0);
        chk("midframe reset data", dato_out, 32'h0);
        pend = 1'b0;
      end
    join
    idle(20);
    rst_n = 1'b1;
    idle(3000);
    chk("after reset valid", dato_valido, 1'b0);
    chk("after reset queue", exp_q.size(), 0);
    model_frame(32'hCAFEF00D, 1'b1, 1'b0);
    send_frame(32'hCAFEF00D, 1'b1);
    chk("post-reset data", dato_out, 32'hCAFEF00D);
    do_ack();

    // Randomized frames, some with a bad stop bit.
    for (int k = 0; k < 8; k++) begin
      w  = $urandom;
      ok = ($urandom_range(0, 3) != 0);
      model_frame(w, ok, 1'b0);
      send_frame(w, ok);
      if (!ok) begin
        rx_in = 1'b0;
        idle($urandom_range(50, 300));
        rx_in = 1'b1;
        idle(10);
        chk("random err valid", dato_valido, 1'b0);
      end else begin
        idle($urandom_range(0, 50));
        do_ack();
      end
      idle($urandom_range(1, 100));
    end

    chk("final queue empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
